// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter serialising the instruction-fetch and data
//            buses onto a single memory port. Each grant is held until the
//            memory acknowledges; an optional timeout completes a hung
//            access with an error word and sets a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned            ADDR_W         = 19,
    parameter int unsigned            DATA_W         = 32,
    parameter int unsigned            TIMEOUT_CYCLES = 0,
    parameter logic [DATA_W-1:0]      ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_valid_i,
    input  logic [ADDR_W-1:0]     instr_addr_i,
    output logic                  instr_ready_o,
    output logic [DATA_W-1:0]     instr_rdata_o,

    input  logic                  data_valid_i,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    input  logic [DATA_W/8-1:0]   data_wstrb_i,
    output logic                  data_ready_o,
    output logic [DATA_W-1:0]     data_rdata_o,

    output logic                  mem_valid_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    output logic                  mem_instr_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  timeout_o
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam bit          c_TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [16:0] c_TO_LIMIT = 17'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Latched request, drives the memory port for the whole transaction
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_instr;
    logic                r_mem_valid;

    // Arbitration history: 1 when the instruction port held the last grant
    logic                r_last_instr;

    logic [15:0]         r_cnt;
    logic                r_timeout;
    logic                r_instr_ready;
    logic                r_data_ready;
    logic [DATA_W-1:0]   r_instr_rdata;
    logic [DATA_W-1:0]   r_data_rdata;

    logic                w_req_any;
    logic                w_grant_instr;
    logic                w_grant;
    logic                w_mem_done;
    logic                w_timeout_hit;
    logic                w_finish;
    logic [16:0]         w_cnt_inc;
    logic                w_is_write;

    // On a tie the port that did not win last time gets the grant
    assign w_req_any     = instr_valid_i | data_valid_i;
    assign w_grant_instr = instr_valid_i & (~data_valid_i | ~r_last_instr);
    assign w_grant       = (r_state == ST_IDLE) & w_req_any;

    // The counter holds the number of completed BUSY cycles, so the current
    // BUSY cycle is the last permitted one when count+1 equals the limit.
    // An acknowledge in that same cycle takes precedence over the timeout.
    assign w_cnt_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_mem_done    = (r_state == ST_BUSY) & mem_ready_i;
    assign w_timeout_hit = (r_state == ST_BUSY) & ~mem_ready_i & c_TO_EN
                           & (w_cnt_inc == c_TO_LIMIT);
    assign w_finish      = w_mem_done | w_timeout_hit;
    assign w_is_write    = (r_wstrb != '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; RESP always returns to IDLE so a still-high valid
    // from the just-served port is not re-granted during its ready pulse
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_any) w_state_next = ST_BUSY;
            ST_BUSY: if (w_finish)  w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the winning request and remember who won
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_instr      <= 1'b0;
            r_last_instr <= 1'b0;
        end else if (w_grant) begin
            r_addr       <= w_grant_instr ? instr_addr_i : data_addr_i;
            r_wdata      <= w_grant_instr ? '0 : data_wdata_i;
            r_wstrb      <= w_grant_instr ? '0 : data_wstrb_i;
            r_instr      <= w_grant_instr;
            r_last_instr <= w_grant_instr;
        end
    end

    // Downstream valid and wait-cycle counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_valid <= 1'b0;
            r_cnt       <= '0;
        end else if (w_grant) begin
            r_mem_valid <= 1'b1;
            r_cnt       <= '0;
        end else if (w_finish) begin
            r_mem_valid <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            r_cnt       <= w_cnt_inc[15:0];
        end
    end

    // Completion: one-cycle ready pulse, read data capture, sticky timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_instr_rdata <= '0;
            r_data_rdata  <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_instr_ready <= w_finish & r_instr;
            r_data_ready  <= w_finish & ~r_instr;
            if (w_mem_done) begin
                if (r_instr) begin
                    r_instr_rdata <= mem_rdata_i;
                end else begin
                    r_data_rdata  <= w_is_write ? '0 : mem_rdata_i;
                end
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
                if (r_instr) begin
                    r_instr_rdata <= ERR_DATA;
                end else begin
                    r_data_rdata  <= ERR_DATA;
                end
            end
        end
    end

    assign mem_valid_o   = r_mem_valid;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign mem_wstrb_o   = r_wstrb;
    assign mem_instr_o   = r_instr;
    assign instr_ready_o = r_instr_ready;
    assign instr_rdata_o = r_instr_rdata;
    assign data_ready_o  = r_data_ready;
    assign data_rdata_o  = r_data_rdata;
    assign timeout_o     = r_timeout;

endmodule
`default_nettype wire
